// File: rtl/alu_bist.sv
// alu_bist: self-test sequencer that sweeps an N-bit ALU through ten opcodes with LFSR operands
// and compresses the results into a 16-bit MISR. Define ALU_BIST_FLAGS_EN to also compress the flags.
module alu_bist #(
    parameter int          N        = 4,
    parameter int          PATTERNS = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  golden,
    input  logic [N-1:0] alu_out,
    input  logic         alu_fn,
    input  logic         alu_fz,
    input  logic         alu_fo,
    input  logic         alu_fc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_s,
    output logic         busy,
    output logic         done,
    output logic [15:0]  signature,
    output logic         pass
);

    localparam logic [15:0] MASK    = 16'hB400;
    localparam logic [3:0]  LAST_OP = 4'd9;
    localparam int          PAT_W   = 9;

    if (N < 1 || N > 8) begin : g_bad_n
        $error("alu_bist: N must be in 1..8");
    end
    if (PATTERNS < 1 || PATTERNS > 256) begin : g_bad_patterns
        $error("alu_bist: PATTERNS must be in 1..256");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("alu_bist: SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        DONE
    } state_t;

    function automatic logic [15:0] galois_shift(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? MASK : 16'h0000);
    endfunction

    function automatic logic [N-1:0] operand_a(input logic [15:0] x);
        return x[N-1:0];
    endfunction

    function automatic logic [N-1:0] operand_b(input logic [15:0] x);
        return x[2*N-1:N];
    endfunction

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        misr;
    logic [3:0]         op_cnt;
    logic [PAT_W-1:0]   pat_cnt;
    logic [15:0]        lfsr_nxt;
    logic [15:0]        misr_data;
    logic               last_pat;
    logic               last_op;

    assign lfsr_nxt = galois_shift(lfsr);
    assign last_pat = (pat_cnt == PAT_W'(PATTERNS - 1));
    assign last_op  = (op_cnt == LAST_OP);

`ifdef ALU_BIST_FLAGS_EN
    always_comb begin
        misr_data          = 16'h0000;
        misr_data[N-1:0]   = alu_out;
        misr_data[N+3:N]   = {alu_fc, alu_fo, alu_fz, alu_fn};
    end
`else
    // Flags are deliberately left out of the signature in this build.
    logic flags_unused;
    assign flags_unused = ^{alu_fc, alu_fo, alu_fz, alu_fn};

    always_comb begin
        misr_data          = 16'h0000;
        misr_data[N-1:0]   = alu_out;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lfsr    <= SEED;
            misr    <= 16'h0000;
            op_cnt  <= 4'd0;
            pat_cnt <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_s   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A new run always restarts from SEED so its signature is repeatable.
                    if (start) begin
                        state   <= DRIVE;
                        lfsr    <= SEED;
                        misr    <= 16'h0000;
                        op_cnt  <= 4'd0;
                        pat_cnt <= '0;
                        alu_a   <= operand_a(SEED);
                        alu_b   <= operand_b(SEED);
                        alu_s   <= 4'd0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                DRIVE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    misr <= galois_shift(misr) ^ misr_data;
                    lfsr <= lfsr_nxt;
                    if (last_pat && last_op) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRIVE;
                        alu_a <= operand_a(lfsr_nxt);
                        alu_b <= operand_b(lfsr_nxt);
                        if (last_pat) begin
                            pat_cnt <= '0;
                            op_cnt  <= op_cnt + 4'd1;
                            alu_s   <= op_cnt + 4'd1;
                        end else begin
                            pat_cnt <= pat_cnt + PAT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign signature = misr;
    assign pass      = done && (misr == golden);

endmodule

// File: tb/tb_alu_bist.sv
// Randomized scoreboard bench for alu_bist: a behavioural ALU drives the DUT and a reference
// model predicts every operand/opcode vector and the final signature of each run.
`timescale 1ns/1ps
module tb_alu_bist;

    localparam int          N    = 4;
    localparam int          P    = 2;
    localparam int          V    = 10 * P;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   s;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  golden = 16'h0000;
    logic [N-1:0] alu_out;
    logic         alu_fn, alu_fz, alu_fo, alu_fc;
    logic [N-1:0] alu_a, alu_b;
    logic [3:0]   alu_s;
    logic         busy, done, pass;
    logic [15:0]  signature;

    logic         stuck = 1'b0;
    logic [N-1:0] xmask = '0;
    logic [N+3:0] alu_res;

    int checks = 0;
    int failures = 0;

    vec_t        exp_vec[$];
    logic [15:0] exp_sig[$];

    alu_bist #(.N(N), .PATTERNS(P), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .golden(golden),
        .alu_out(alu_out), .alu_fn(alu_fn), .alu_fz(alu_fz), .alu_fo(alu_fo), .alu_fc(alu_fc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .busy(busy), .done(done), .signature(signature), .pass(pass)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural ALU under test; returns {c, o, z, n, result}.
    function automatic logic [N+3:0] env_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [3:0] s, input logic stk,
                                             input logic [N-1:0] msk);
        int          ia, ib, sum;
        logic [N-1:0] r;
        logic         c, o;
        ia = int'(a);
        ib = int'(b);
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (s)
            4'd0: begin sum = ia + ib; r = N'(sum); c = (sum > 15);
                        o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
            4'd1: begin sum = ia - ib; r = N'(sum); c = (sum < 0);
                        o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
            4'd2: begin r = N'(ia * 2); c = a[N-1]; o = a[N-1] ^ a[N-2]; end
            4'd3: begin r = N'((ia / 2) + (a[N-1] ? 8 : 0)); c = a[0]; end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = N'(ia << (ib % 4));
            4'd8: r = N'(ia >> (ib % 4));
            4'd9: r = N'(15 - ia);
            default: r = '0;
        endcase
        if (stk) return '0;
        return {c, o, (r ^ msk) == '0, r[N-1] ^ msk[N-1], r ^ msk};
    endfunction

    always_comb begin
        alu_res = env_alu(alu_a, alu_b, alu_s, stuck, xmask);
    end
    assign alu_out = alu_res[N-1:0];
    assign {alu_fc, alu_fo, alu_fz, alu_fn} = alu_res[N+3:N];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference model of one complete uninterrupted run.
    task automatic push_expected(output logic [15:0] sig, output vec_t last);
        logic [15:0]  x, m, d;
        logic [N+3:0] r;
        vec_t         v;
        x = SEED;
        m = 16'h0000;
        v = '0;
        for (int i = 0; i < V; i++) begin
            v.a = x[N-1:0];
            v.b = x[2*N-1:N];
            v.s = 4'(i / P);
            exp_vec.push_back(v);
            r = env_alu(v.a, v.b, v.s, stuck, xmask);
`ifdef ALU_BIST_FLAGS_EN
            d = 16'(r);
`else
            d = 16'(r[N-1:0]);
`endif
            m = lfsr_step(m) ^ d;
            x = lfsr_step(x);
        end
        exp_sig.push_back(m);
        sig = m;
        last = v;
    endtask

    // Monitor: compares every busy cycle and every done rising edge against the scoreboard.
    int          run_cyc = 0;
    logic        done_q = 1'b0;
    logic        busy_q = 1'b0;
    logic [15:0] mon_sig;
    always @(negedge clk) begin
        if (rst) begin
            run_cyc = 0;
            done_q = 1'b0;
            busy_q = 1'b0;
        end else begin
            if (busy) begin
                if (exp_vec.size() == 0) begin
                    check("unexpected_busy", 32'(busy), 32'h0);
                end else begin
                    check("vector", 32'({alu_a, alu_b, alu_s}), 32'(exp_vec[0]));
                    if (run_cyc % 2 == 1) void'(exp_vec.pop_front());
                end
                run_cyc++;
            end
            if (done && !done_q) begin
                check("busy_window", 32'((run_cyc == 2 * V) && busy_q && !busy), 32'h1);
                if (exp_sig.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    mon_sig = exp_sig.pop_front();
                    check("signature", 32'(signature), 32'(mon_sig));
                    check("pass", 32'(pass), 32'(mon_sig == golden));
                end
                run_cyc = 0;
            end
            done_q = done;
            busy_q = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int hold, input logic [15:0] gold, input logic stk,
                             input logic [N-1:0] msk, output logic [15:0] sig, output vec_t last);
        stuck = stk;
        xmask = msk;
        push_expected(sig, last);
        golden = gold;
        start = 1'b1;
        tick();
        check("first_a", 32'(alu_a), 32'h1);
        check("first_b", 32'(alu_b), 32'hE);
        check("first_s", 32'(alu_s), 32'h0);
        repeat (hold) tick();
        start = 1'b0;
    endtask

    task automatic run_finish(input vec_t last);
        int t;
        t = 0;
        while (!done && t < 4 * V) begin
            tick();
            t++;
        end
        check("done_timeout", 32'(done), 32'h1);
        repeat (3) tick();
        check("hold_ops", 32'({alu_a, alu_b, alu_s}), 32'(last));
        check("done_stays", 32'({busy, done}), 32'h1);
    endtask

    task automatic run(input int hold, input logic [15:0] gold, input logic stk,
                       input logic [N-1:0] msk, output logic [15:0] sig);
        vec_t last;
        run_start(hold, gold, stk, msk, sig, last);
        run_finish(last);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_ops"}, 32'({alu_a, alu_b, alu_s}), 32'h0);
        check({tag, "_sig"}, 32'(signature), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sig;
        vec_t        last;
        logic [N-1:0] m;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset_state("reset");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) tick();
        check_reset_state("idle");

        // Plain run from IDLE with a matching golden.
        m = N'($urandom);
        stuck = 1'b0;
        xmask = m;
        run(0, 16'h0000, 1'b0, m, sig);
        golden = sig;
        #1 check("pass_match", 32'(pass), 32'h1);

        // Start held through the whole busy window must not restart.
        run(2 * V - 1, 16'(sig), 1'b0, m, sig);

        // Abort during vector 5, then an uninterrupted run must reproduce everything.
        run_start(0, sig, 1'b0, m, sig, last);
        repeat (10) tick();
        rst = 1'b1;
        exp_vec.delete();
        exp_sig.delete();
        #1 check_reset_state("abort");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        check("abort_no_done", 32'(done), 32'h0);
        run(0, sig, 1'b0, m, sig);
        check("abort_pass", 32'(pass), 32'h1);

        // Stuck-at-zero ALU.
        run(0, 16'h0000, 1'b1, '0, sig);
        check("stuck_sig", 32'(signature), 32'h0);
        check("stuck_pass0", 32'(pass), 32'h1);
        golden = 16'h1234;
        #1 check("stuck_pass1234", 32'(pass), 32'h0);
        stuck = 1'b0;

        // Randomized back-to-back runs, each started from DONE.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] g;
            m = N'($urandom);
            g = 16'($urandom);
            run($urandom_range(0, 2 * V - 1), g, 1'b0, m, sig);
            golden = ($urandom_range(0, 1) == 1) ? sig : (sig ^ 16'(1 << $urandom_range(0, 15)));
            #1 check("pass_rand", 32'(pass), 32'(golden == sig));
        end

        check("scoreboard_empty", 32'(exp_vec.size() + exp_sig.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
